// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester-side and UART-side signals of uart_tx_arbiter.
//
//   req_valid  [M]        requester i has a frame pending
//   req_data   [M][N][8]  payload of requester i, lane 0 is the first byte
//   req_len    [M][LW]    payload byte count, 0..N
//   req_ready  [M]        one-cycle capture pulse to the granted requester
//   can_push   [LW]       free slots reported by the UART FIFO
//   push       [LW]       bytes written to the UART this cycle
//   data_i     [N][8]     bytes to the UART, lane 0 written first
//
// master: the arbiter.  slave: requesters plus the UART FIFO.
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int N = 8,
    parameter int M = 4
);
    localparam int LW = $clog2(N + 1);

    logic [M-1:0]                req_valid;
    logic [M-1:0][N-1:0][7:0]    req_data;
    logic [M-1:0][LW-1:0]        req_len;
    logic [M-1:0]                req_ready;
    logic [LW-1:0]               can_push;
    logic [LW-1:0]               push;
    logic [N-1:0][7:0]           data_i;

    modport master (
        input  req_valid, req_data, req_len, can_push,
        output req_ready, push, data_i
    );

    modport slave (
        output req_valid, req_data, req_len, can_push,
        input  req_ready, push, data_i
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one multi-byte-push UART transmitter between M frame requesters.
// Requesters are granted round-robin; each grant captures one frame, prefixes
// it with a header byte (HDR_BASE | id) and drains it into the UART FIFO as
// fast as can_push allows.
//
// Ports:
//   clk     system clock
//   arstn   synchronous active-low reset
//   bus     uart_tx_arbiter_if.master (requester handshake + UART push side)
//   busy    a frame is being transferred
//   cur_id  id of the frame in transfer, holds the last id when idle
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int         N        = 8,
    parameter int         M        = 4,
    parameter logic [7:0] HDR_BASE = 8'hA0
) (
    input  logic              clk,
    input  logic              arstn,
    uart_tx_arbiter_if.master bus,
    output logic              busy,
    output logic [3:0]        cur_id
);
    localparam int LW = $clog2(N + 1);
    localparam int RW = $clog2(N + 2);
    localparam int PW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state, state_next;
    logic [N:0][7:0]     buffer, buffer_next;
    logic [RW-1:0]       rem, rem_next;
    logic [PW-1:0]       rr_ptr, rr_ptr_next;
    logic [LW-1:0]       push_r, push_next;
    logic [N-1:0][7:0]   data_r, data_next;
    logic [M-1:0]        ready_r, ready_next;
    logic                busy_next;
    logic [3:0]          cur_id_next;

    logic                found;
    logic [PW-1:0]       grant;
    logic [PW-1:0]       idx;
    logic [LW-1:0]       len_c;
    logic [RW-1:0]       k;

    assign bus.push      = push_r;
    assign bus.data_i    = data_r;
    assign bus.req_ready = ready_r;

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int i = 0; i < M; i++) begin
            idx = PW'((int'(rr_ptr) + i) % M);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    // Clamped payload length of the granted requester, and the number of
    // bytes that can move this cycle: min(rem, can_push, N).
    always_comb begin
        len_c = bus.req_len[grant];
        if (int'(len_c) > N) len_c = LW'(N);
        k = rem;
        if (int'(bus.can_push) < int'(k)) k = RW'(bus.can_push);
        if (int'(k) > N) k = RW'(N);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_next  = state;
        buffer_next = buffer;
        rem_next    = rem;
        rr_ptr_next = rr_ptr;
        push_next   = '0;
        data_next   = '0;
        ready_next  = '0;
        busy_next   = busy;
        cur_id_next = cur_id;
        case (state)
            IDLE: begin
                if (found) begin
                    ready_next[grant] = 1'b1;
                    buffer_next       = '0;
                    buffer_next[0]    = HDR_BASE | {4'b0000, 4'(grant)};
                    for (int j = 1; j <= N; j++) begin
                        if (j <= int'(len_c)) buffer_next[j] = bus.req_data[grant][j-1];
                    end
                    rem_next    = RW'(len_c) + RW'(1);
                    cur_id_next = 4'(grant);
                    busy_next   = 1'b1;
                    if (int'(grant) == M - 1) rr_ptr_next = '0;
                    else                      rr_ptr_next = grant + PW'(1);
                    state_next  = SEND;
                end
            end
            SEND: begin
                push_next = LW'(k);
                for (int j = 0; j < N; j++) begin
                    if (j < int'(k)) data_next[j] = buffer[j];
                end
                // Drop the k bytes just handed to the UART.
                buffer_next = buffer >> {k, 3'b000};
                rem_next    = rem - k;
                if (rem == k) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            state  <= IDLE;
            buffer <= '0;
            rem    <= '0;
            rr_ptr <= '0;
            push_r <= '0;
            data_r <= '0;
            ready_r <= '0;
            busy   <= 1'b0;
            cur_id <= '0;
        end else begin
            state  <= state_next;
            buffer <= buffer_next;
            rem    <= rem_next;
            rr_ptr <= rr_ptr_next;
            push_r <= push_next;
            data_r <= data_next;
            ready_r <= ready_next;
            busy   <= busy_next;
            cur_id <= cur_id_next;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed testbench for uart_tx_arbiter (N=8, M=4, HDR_BASE=8'hA0).
// Inputs change and outputs are sampled just after the falling clock edge.
// A monitor collects every pushed byte into tx_q so byte order can be checked.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    localparam int N = 8;
    localparam int M = 4;

    logic       clk = 1'b0;
    logic       arstn;
    logic       busy;
    logic [3:0] cur_id;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] tx_q[$];

    int cp_seq[5]   = '{3, 0, 0, 4, 8};
    int push_seq[5] = '{3, 0, 0, 4, 2};
    int rr_exp[4]   = '{0, 1, 3, 0};
    int sim_exp[5]  = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N(N), .M(M)) bus ();

    uart_tx_arbiter #(.N(N), .M(M), .HDR_BASE(8'hA0)) dut (
        .clk    (clk),
        .arstn  (arstn),
        .bus    (bus),
        .busy   (busy),
        .cur_id (cur_id)
    );

    // Byte collector: everything the arbiter hands to the UART, in order.
    always @(negedge clk) begin
        for (int j = 0; j < N; j++) begin
            if (j < int'(bus.push)) tx_q.push_back(bus.data_i[j]);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7:0] payload(input int i, input int j);
        return 8'((i << 4) + j + 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [M-1:0] valid, input int len, input int cp);
        bus.req_valid = valid;
        for (int i = 0; i < M; i++) bus.req_len[i] = 4'(len);
        bus.can_push = 4'(cp);
    endtask

    task automatic applyReset();
        arstn = 1'b0;
        applyStimulus('0, 0, 0);
        tick();
        tick();
        arstn = 1'b1;
        tx_q.delete();
    endtask

    // Waits up to 20 cycles for a req_ready pulse and returns the granted id.
    task automatic waitGrant(input string tag, output int id, output int cycles);
        logic seen;
        seen   = 1'b0;
        id     = -1;
        cycles = 0;
        while (!seen && cycles < 20) begin
            tick();
            cycles++;
            if (bus.req_ready != '0) begin
                seen = 1'b1;
                for (int i = 0; i < M; i++) if (bus.req_ready[i]) id = i;
                checkOutput({tag, "_onehot"}, 64'($countones(bus.req_ready)), 64'd1);
                checkOutput({tag, "_cur_id"}, 64'(cur_id), 64'(id));
                checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
            end
        end
        checkOutput({tag, "_seen"}, 64'(seen), 64'd1);
    endtask

    initial begin
        int id, cyc;
        logic [N-1:0][7:0] ev;

        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                bus.req_data[i][j] = payload(i, j);

        // ---- reset state ----
        applyReset();
        checkOutput("rst_push",   64'(bus.push), 64'd0);
        checkOutput("rst_data",   64'(bus.data_i), 64'd0);
        checkOutput("rst_ready",  64'(bus.req_ready), 64'd0);
        checkOutput("rst_busy",   64'(busy), 64'd0);
        checkOutput("rst_cur_id", 64'(cur_id), 64'd0);

        // ---- single frame, len 8, can_push 8 ----
        applyStimulus(4'b0001, 8, 8);
        waitGrant("t1", id, cyc);
        checkOutput("t1_id",      64'(id), 64'd0);
        checkOutput("t1_latency", 64'(cyc), 64'd1);
        checkOutput("t1_push0",   64'(bus.push), 64'd0);
        applyStimulus('0, 8, 8);
        tick();
        ev = '0;
        ev[0] = 8'hA0;
        for (int j = 1; j < N; j++) ev[j] = payload(0, j - 1);
        checkOutput("t1_ready_drop", 64'(bus.req_ready), 64'd0);
        checkOutput("t1_push1",  64'(bus.push), 64'd8);
        checkOutput("t1_data1",  64'(bus.data_i), 64'(ev));
        checkOutput("t1_busy1",  64'(busy), 64'd1);
        tick();
        checkOutput("t1_push2",  64'(bus.push), 64'd1);
        checkOutput("t1_data2",  64'(bus.data_i), 64'h08);
        checkOutput("t1_busy2",  64'(busy), 64'd0);
        tick();
        checkOutput("t1_push3",  64'(bus.push), 64'd0);
        checkOutput("t1_bytes",  64'(tx_q.size()), 64'd9);
        if (tx_q.size() == 9) begin
            checkOutput("t1_hdr", 64'(tx_q[0]), 64'hA0);
            for (int j = 1; j < 9; j++)
                checkOutput($sformatf("t1_byte%0d", j), 64'(tx_q[j]), 64'(payload(0, j - 1)));
        end

        // ---- round robin, requesters 0,1,3 held ----
        applyReset();
        applyStimulus(4'b1011, 2, 8);
        for (int g = 0; g < 4; g++) begin
            waitGrant($sformatf("rr%0d", g), id, cyc);
            checkOutput($sformatf("rr%0d_id", g), 64'(id), 64'(rr_exp[g]));
            if (g > 0) checkOutput($sformatf("rr%0d_gap", g), 64'(cyc), 64'd2);
        end
        applyStimulus('0, 2, 8);
        tick();
        tick();
        checkOutput("rr_bytes", 64'(tx_q.size()), 64'd12);
        if (tx_q.size() == 12) begin
            for (int g = 0; g < 4; g++) begin
                checkOutput($sformatf("rr_hdr%0d", g), 64'(tx_q[3 * g]), 64'(8'hA0 | 8'(rr_exp[g])));
                checkOutput($sformatf("rr_pl%0d", g), 64'(tx_q[3 * g + 2]), 64'(payload(rr_exp[g], 1)));
            end
        end

        // ---- backpressure ----
        applyReset();
        applyStimulus(4'b0001, 8, 3);
        waitGrant("bp", id, cyc);
        applyStimulus('0, 8, 3);
        for (int i = 0; i < 5; i++) begin
            bus.can_push = 4'(cp_seq[i]);
            tick();
            checkOutput($sformatf("bp_push%0d", i), 64'(bus.push), 64'(push_seq[i]));
            checkOutput($sformatf("bp_busy%0d", i), 64'(busy), (i < 4) ? 64'd1 : 64'd0);
            if (i == 0) checkOutput("bp_data0", 64'(bus.data_i), 64'h0201A0);
            if (i == 1) checkOutput("bp_data1", 64'(bus.data_i), 64'd0);
        end
        tick();
        checkOutput("bp_bytes", 64'(tx_q.size()), 64'd9);
        if (tx_q.size() == 9) begin
            checkOutput("bp_hdr", 64'(tx_q[0]), 64'hA0);
            for (int j = 1; j < 9; j++)
                checkOutput($sformatf("bp_byte%0d", j), 64'(tx_q[j]), 64'(payload(0, j - 1)));
        end

        // ---- header-only frame ----
        applyReset();
        applyStimulus(4'b0010, 0, 8);
        waitGrant("len0", id, cyc);
        checkOutput("len0_id", 64'(id), 64'd1);
        applyStimulus('0, 0, 8);
        tick();
        checkOutput("len0_push", 64'(bus.push), 64'd1);
        checkOutput("len0_data", 64'(bus.data_i), 64'hA1);
        checkOutput("len0_busy", 64'(busy), 64'd0);
        tick();
        checkOutput("len0_push_after", 64'(bus.push), 64'd0);

        // ---- length clamp ----
        applyReset();
        applyStimulus(4'b1000, 12, 8);
        waitGrant("clamp", id, cyc);
        checkOutput("clamp_id", 64'(id), 64'd3);
        applyStimulus('0, 12, 8);
        tick();
        checkOutput("clamp_push1", 64'(bus.push), 64'd8);
        tick();
        checkOutput("clamp_push2", 64'(bus.push), 64'd1);
        checkOutput("clamp_busy",  64'(busy), 64'd0);
        tick();
        checkOutput("clamp_bytes", 64'(tx_q.size()), 64'd9);
        if (tx_q.size() == 9) begin
            checkOutput("clamp_hdr",  64'(tx_q[0]), 64'hA3);
            checkOutput("clamp_last", 64'(tx_q[8]), 64'h38);
        end

        // ---- reset in the middle of a frame ----
        applyReset();
        applyStimulus(4'b0001, 8, 4);
        waitGrant("mid", id, cyc);
        applyStimulus('0, 8, 4);
        tick();
        checkOutput("mid_push4", 64'(bus.push), 64'd4);
        arstn = 1'b0;
        tick();
        checkOutput("mid_rst_push",  64'(bus.push), 64'd0);
        checkOutput("mid_rst_busy",  64'(busy), 64'd0);
        checkOutput("mid_rst_id",    64'(cur_id), 64'd0);
        arstn = 1'b1;
        applyStimulus(4'b0100, 8, 8);
        waitGrant("mid_new", id, cyc);
        checkOutput("mid_new_id", 64'(id), 64'd2);
        applyStimulus('0, 8, 8);
        tick();
        checkOutput("mid_new_push", 64'(bus.push), 64'd8);
        checkOutput("mid_new_hdr",  64'(bus.data_i[0]), 64'hA2);
        checkOutput("mid_bytes",    64'(tx_q.size()), 64'd12);

        // ---- simultaneous arrival after reset ----
        applyReset();
        applyStimulus(4'b1111, 1, 8);
        for (int g = 0; g < 5; g++) begin
            waitGrant($sformatf("sim%0d", g), id, cyc);
            checkOutput($sformatf("sim%0d_id", g), 64'(id), 64'(sim_exp[g]));
        end
        applyStimulus('0, 1, 8);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
